// File: rtl/prog_loader_mem_pkg.sv
// Shared types and constants for the program memory and its byte-serial loader.
package prog_loader_mem_pkg;

    localparam int PROG_DEPTH = 16;
    localparam int PROG_AW    = 4;
    localparam int PROG_DW    = 8;

    localparam logic [PROG_DW-1:0] NOP_WORD = 8'h00;

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } loader_state_t;

    typedef struct packed {
        logic [PROG_AW-1:0] addr;
    } virt_addr_t;

    // Only virt_addr.addr selects an instruction; seg is carried for the core's benefit.
    typedef struct packed {
        logic [3:0] seg;
        virt_addr_t virt_addr;
    } addr_t;

    typedef struct packed {
        logic [3:0] opcode;
        logic [3:0] imm;
    } data_t;

endpackage

// File: rtl/prog_mem_array.sv
// DEPTH x DW register file: one combinational read port, one synchronous write port, async clear.
module prog_mem_array #(
    parameter int DEPTH = 16,
    parameter int AW    = 4,
    parameter int DW    = 8
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [DW-1:0] o_rdata
);

    logic [DEPTH-1:0][DW-1:0] r_mem;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_mem <= '0;
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/prog_loader_mem.sv
// Program memory feeding the CPU core, rewritable at run time through a valid/ready byte port.
module prog_loader_mem
    import prog_loader_mem_pkg::*;
#(
    parameter int DEPTH = PROG_DEPTH,
    parameter int AW    = PROG_AW,
    parameter int DW    = PROG_DW
) (
    input  logic          i_clock,
    input  logic          i_reset,
    input  addr_t         i_addr,
    output data_t         o_data,
    output logic          o_cpu_hold,
    input  logic          i_ld_start,
    input  logic          i_ld_abort,
    input  logic          i_ld_valid,
    input  logic [DW-1:0] i_ld_data,
    output logic          o_ld_ready,
    output logic          o_ld_done,
    output logic [AW:0]   o_ld_count,
    output logic [DW-1:0] o_ld_sum
);

    loader_state_t r_state;
    logic [AW-1:0] r_ptr;
    logic [AW:0]   r_ld_count;
    logic [DW-1:0] r_ld_sum;
    logic          r_ld_ready;
    logic          r_ld_done;

    logic          w_hs;
    logic          w_last;
    logic [DW-1:0] w_rdata;
    logic          w_unused;

    assign w_hs     = i_ld_valid & r_ld_ready;
    assign w_last   = w_hs && (r_ptr == AW'(DEPTH - 1));
    assign w_unused = &{1'b0, i_addr.seg};

    prog_mem_array #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .DW    (DW)
    ) u_mem (
        .i_clk   (i_clock),
        .i_rst   (i_reset),
        .i_we    (w_hs),
        .i_waddr (r_ptr),
        .i_wdata (i_ld_data),
        .i_raddr (i_addr.virt_addr.addr),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state    <= RUN;
            r_ptr      <= '0;
            r_ld_count <= '0;
            r_ld_sum   <= '0;
            r_ld_ready <= 1'b0;
            r_ld_done  <= 1'b0;
        end else begin
            case (r_state)
                RUN: begin
                    if (i_ld_start) begin
                        r_state    <= LOAD;
                        r_ptr      <= '0;
                        r_ld_count <= '0;
                        r_ld_sum   <= '0;
                        r_ld_ready <= 1'b1;
                    end
                end
                LOAD: begin
                    if (w_hs) begin
                        r_ptr      <= r_ptr + 1'b1;
                        r_ld_count <= r_ld_count + 1'b1;
                        r_ld_sum   <= r_ld_sum + i_ld_data;
                    end
                    // A byte arriving with abort is still counted above before leaving.
                    if (w_last || i_ld_abort) begin
                        r_state    <= DONE;
                        r_ld_ready <= 1'b0;
                        r_ld_done  <= 1'b1;
                    end
                end
                DONE: begin
                    r_state   <= RUN;
                    r_ld_done <= 1'b0;
                end
                default: begin
                    r_state    <= RUN;
                    r_ld_ready <= 1'b0;
                    r_ld_done  <= 1'b0;
                end
            endcase
        end
    end

    // The core sees NOPs whenever it is held, so nothing half-loaded is ever fetched.
    assign o_data     = (r_state == RUN) ? data_t'(w_rdata) : data_t'(NOP_WORD);
    assign o_cpu_hold = (r_state != RUN);
    assign o_ld_ready = r_ld_ready;
    assign o_ld_done  = r_ld_done;
    assign o_ld_count = r_ld_count;
    assign o_ld_sum   = r_ld_sum;

endmodule

// File: tb/tb_prog_loader_mem.sv
// Randomized and directed checks of prog_loader_mem against a behavioural loader model.
module tb_prog_loader_mem;
    import prog_loader_mem_pkg::*;

    logic        clk = 1'b0;
    logic        i_reset;
    addr_t       i_addr;
    data_t       o_data;
    logic        o_cpu_hold;
    logic        i_ld_start, i_ld_abort, i_ld_valid;
    logic [7:0]  i_ld_data;
    logic        o_ld_ready, o_ld_done;
    logic [4:0]  o_ld_count;
    logic [7:0]  o_ld_sum;

    int n_chk = 0;
    int n_bad = 0;
    int hold_cycles, done_pulses;

    // Model: program image plus "loading" / "finishing" flags.
    logic [7:0] m_mem [16];
    int         m_ptr, m_cnt;
    logic [7:0] m_sum;
    bit         m_load, m_fin;

    always #5 clk = ~clk;

    prog_loader_mem dut (
        .i_clock    (clk),
        .i_reset    (i_reset),
        .i_addr     (i_addr),
        .o_data     (o_data),
        .o_cpu_hold (o_cpu_hold),
        .i_ld_start (i_ld_start),
        .i_ld_abort (i_ld_abort),
        .i_ld_valid (i_ld_valid),
        .i_ld_data  (i_ld_data),
        .o_ld_ready (o_ld_ready),
        .o_ld_done  (o_ld_done),
        .o_ld_count (o_ld_count),
        .o_ld_sum   (o_ld_sum)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_mem[i] = 8'h00;
        m_ptr = 0; m_cnt = 0; m_sum = 8'h00; m_load = 0; m_fin = 0;
    endtask

    task automatic model_step(input bit st, input bit ab, input bit vl, input logic [7:0] d);
        if (m_fin) begin
            m_fin = 0;
        end else if (m_load) begin
            bit last;
            last = 0;
            if (vl) begin
                m_mem[m_ptr] = d;
                last  = (m_ptr == 15);
                m_ptr = (m_ptr + 1) % 16;
                m_cnt = m_cnt + 1;
                m_sum = m_sum + d;
            end
            if (last || ab) begin
                m_load = 0;
                m_fin  = 1;
            end
        end else if (st) begin
            m_load = 1;
            m_ptr = 0; m_cnt = 0; m_sum = 8'h00;
        end
    endtask

    task automatic check_outputs(input logic [3:0] a);
        bit running;
        running = !m_load && !m_fin;
        chk("ready", o_ld_ready, m_load);
        chk("hold",  o_cpu_hold, !running);
        chk("done",  o_ld_done,  m_fin);
        chk("count", o_ld_count, m_cnt);
        chk("sum",   o_ld_sum,   m_sum);
        chk("data",  o_data,     running ? m_mem[a] : 8'h00);
    endtask

    // One clock: drive, check at negedge, advance model at posedge.
    task automatic cyc(input bit st, input bit ab, input bit vl, input logic [7:0] d, input logic [3:0] a);
        i_ld_start = st; i_ld_abort = ab; i_ld_valid = vl; i_ld_data = d;
        i_addr.seg = 4'($urandom);
        i_addr.virt_addr.addr = a;
        @(negedge clk);
        check_outputs(a);
        if (o_cpu_hold) hold_cycles++;
        if (o_ld_done)  done_pulses++;
        @(posedge clk);
        if (i_reset) model_reset();
        else         model_step(st, ab, vl, d);
        #1;
    endtask

    task automatic sweep();
        for (int a = 0; a < 16; a++) cyc(0, 0, 0, 8'h00, 4'(a));
    endtask

    initial begin
        i_reset = 1'b1;
        i_ld_start = 0; i_ld_abort = 0; i_ld_valid = 0; i_ld_data = 8'h00;
        i_addr = '0;
        model_reset();
        #1;
        chk("rst_hold",  o_cpu_hold, 0);
        chk("rst_ready", o_ld_ready, 0);
        chk("rst_done",  o_ld_done,  0);
        chk("rst_count", o_ld_count, 0);
        chk("rst_sum",   o_ld_sum,   0);
        #1 i_reset = 1'b0;
        sweep();

        // Back-to-back load of 0x10..0x1F.
        hold_cycles = 0; done_pulses = 0;
        cyc(1, 0, 1, 8'hEE, 0);
        for (int i = 0; i < 16; i++) cyc(0, 0, 1, 8'(8'h10 + i), 4'($urandom));
        cyc(0, 0, 0, 8'h00, 0);
        cyc(0, 0, 0, 8'h00, 5);
        chk("b2b_hold17", hold_cycles, 17);
        chk("b2b_done1",  done_pulses, 1);
        chk("b2b_count",  o_ld_count, 16);
        chk("b2b_sum",    o_ld_sum,   8'h78);
        chk("b2b_addr5",  o_data,     8'h15);
        sweep();

        // Same program with valid toggling; start also pulsed mid-load and in the done cycle.
        cyc(1, 0, 0, 8'h00, 0);
        for (int i = 0; i < 16; i++) begin
            cyc(i == 6, 0, 0, 8'h5A, 4'($urandom));
            cyc(0, 0, 1, 8'(8'h10 + i), 4'($urandom));
        end
        cyc(1, 0, 0, 8'h00, 0);
        cyc(0, 0, 0, 8'h00, 5);
        chk("tog_count", o_ld_count, 16);
        chk("tog_sum",   o_ld_sum,   8'h78);
        chk("tog_addr5", o_data,     8'h15);
        sweep();

        // Three bytes, abort alongside the third: A1+B2+C3 = 0x216.
        cyc(1, 0, 0, 8'h00, 0);
        cyc(0, 0, 1, 8'hA1, 0);
        cyc(0, 0, 1, 8'hB2, 0);
        cyc(0, 1, 1, 8'hC3, 0);
        cyc(0, 0, 0, 8'h00, 3);
        chk("abt_count", o_ld_count, 3);
        chk("abt_sum",   o_ld_sum,   8'h16);
        chk("abt_addr3", o_data,     8'h13);
        sweep();

        // Reset after seven bytes of a new load.
        cyc(1, 0, 0, 8'h00, 0);
        for (int i = 0; i < 7; i++) cyc(0, 0, 1, 8'($urandom), 0);
        i_reset = 1'b1;
        #1;
        chk("mid_rst_hold",  o_cpu_hold, 0);
        chk("mid_rst_ready", o_ld_ready, 0);
        chk("mid_rst_count", o_ld_count, 0);
        chk("mid_rst_data",  o_data,     8'h00);
        model_reset();
        cyc(0, 0, 1, 8'hFF, 0);
        i_reset = 1'b0;
        sweep();

        // Random traffic.
        for (int n = 0; n < 600; n++) begin
            cyc(($urandom % 8) == 0, ($urandom % 16) == 0, $urandom % 2,
                8'($urandom), 4'($urandom));
        end
        sweep();

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
